axi_bar_responder: RTL
======================

# axi_bar_responder

AXI4 memory-mapped slave that terminates the master port of the PCIe AXI bridge and serves host BAR accesses. It provides an identification word, a write-beat counter and a byte-addressable scratch RAM, all 128 bits wide. It sits directly on the bridge's master interface in the `axi_clk_pcie` domain, and is the responder end of the bridge's host-initiated read/write traffic.

## Interface
- `DEPTH`, 64: number of 128-bit words in the map; a power of two, at least 4.
- `ID_VALUE`, 128'h0000_0000_0000_0000_0000_0000_ACE0_0001: constant returned at word 0.
- `axi_clk_pcie` input, 1: sole clock, the bridge's AXI clock output.
- `sys_resetn` input, 1: asynchronous active-low reset.
- `s_axi_pcie` AXI.S, interface: AXI4 slave with 32-bit addresses and 128-bit data. It carries the AW/W/B/AR/R channels plus len/size/burst/prot/lock/cache, and has no ID signals.

## Operation
- Map: word index is `addr[ADDR_W+3:4]`, with `ADDR_W = $clog2(DEPTH)`. Byte offset `addr >= DEPTH*16` is out of range.
- Word 0 returns `ID_VALUE`. It is read-only; writes are dropped with OKAY.
- Word 1 holds the write-beat counter in bits [31:0]; bits [127:32] read as 0.
  - The counter increments on every accepted in-range W beat and wraps at 2^32.
  - It is read-only; writes to word 1 are dropped but still counted.
- Words 2..DEPTH-1 are scratch RAM. Writes honour `wstrb` per byte.
- Bursts:
  - INCR and WRAP both step the address by `1<<size` bytes per beat (WRAP is treated as INCR).
  - FIXED holds the address for every beat.
  - `len` is 0..255.
  - Out-of-range status is evaluated per beat.
- Write FSM states are W_IDLE, W_DATA and W_RESP:
  - W_IDLE: `awready`=1. An AW handshake latches addr/len/size/burst and moves to W_DATA.
  - W_DATA: `wready`=1. Each handshake writes one beat and decrements the beat count. The final beat moves to W_RESP.
  - W_RESP: `bvalid`=1 until `bready`, then returns to W_IDLE.
- Write termination and response:
  - The beat count governs termination; `wlast` does not.
  - `bresp` is SLVERR (2'b10) if `wlast` is not asserted exactly on the final beat.
  - Otherwise `bresp` is OKAY, unless the configuration option below applies.
- Read FSM states are R_IDLE and R_DATA:
  - R_IDLE: `arready`=1. An AR handshake latches the burst parameters and moves to R_DATA.
  - R_DATA: `rvalid`=1 with a registered beat. On `rvalid&rready` the next beat is presented in the following cycle, or the FSM returns to R_IDLE after the beat with `rlast`.
  - `rdata`, `rresp` and `rlast` are held stable while `rvalid & !rready`.
- The read and write FSMs are independent. Each accepts only one burst outstanding at a time.
- A read and a write to the same word in the same cycle: the read returns the old value.

## Timing
- Reset values: `awready`=0, `wready`=0, `bvalid`=0, `bresp`=0, `arready`=0, `rvalid`=0, `rdata`=0, `rresp`=0, `rlast`=0. The write counter is 0.
- In the first cycle after reset deassertion, the FSMs enter their idle states. `awready` and `arready` go to 1 on the next edge.
- Reset asserted mid-burst: both FSMs return to idle immediately and the partial burst is abandoned. RAM contents are not cleared.
- AW handshake to `wready`=1: 1 cycle.
- Final W beat to `bvalid`: 1 cycle.
- AR handshake to first `rvalid`: 1 cycle.
- Sustained rate is 1 beat/cycle in each direction.
- B to next `awready`, and last R to next `arready`: 1 cycle.

## Configuration
- `AXI_BAR_DECERR_EN` defined:
  - An out-of-range beat makes `bresp` DECERR (2'b11) for that burst. SLVERR takes precedence over DECERR.
  - Out-of-range read beats return `rresp`=DECERR with `rdata`=0.
- Undefined: out-of-range writes are dropped with OKAY, and out-of-range reads return 0 with OKAY.

## Structure
- Package `axi_bar_pkg` holds:
  - the `w_state_t` and `r_state_t` enums;
  - `RESP_OKAY`, `RESP_SLVERR` and `RESP_DECERR`;
  - `BURST_FIXED`, `BURST_INCR` and `BURST_WRAP`;
  - `WORD_ID`=0 and `WORD_WRCNT`=1;
  - the address step function.
- Sub-module `axi_bar_ram` is a 1-write/1-read, 128-bit RAM with 16 byte enables and combinational read. The responder registers its output.

## Test plan
- Single read of 0x00 -> `rdata`=`ID_VALUE`, `rresp`=0, `rlast`=1, `rvalid` 1 cycle after AR.
- INCR write to 0x20, len=3, all strobes, data 1..4; then read of 0x20, len=3 -> data 1..4 back-to-back, `rlast` on beat 4, `bresp`=0. Read of 0x10 -> bits [31:0]=4.
- Write to 0x30 with `wstrb`=16'h000F and data all-ones over prior zeros -> read returns 128'hFFFF_FFFF.
- Write len=1 with `wlast` on beat 0 -> `bresp`=2'b10, both beats still written.
- Read of 0x400 (DEPTH=64) -> `rdata`=0; `rresp`=2'b11 with `AXI_BAR_DECERR_EN`, 0 without.
- `rready` held low 5 cycles mid-burst, then `sys_resetn` pulsed -> `rdata` stable while stalled; after reset all outputs 0, then `arready`=1 and a new read returns correct data.

Source files
------------

// File: rtl/axi_bar_pkg.sv
// Shared types, response/burst encodings and address stepping for axi_bar_responder.
package axi_bar_pkg;

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
   typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   localparam int unsigned WORD_ID    = 0;
   localparam int unsigned WORD_WRCNT = 1;

   // WRAP deliberately steps like INCR; the reserved encoding does the same.
   function automatic logic [31:0] next_addr(input logic [31:0] addr,
                                             input logic [2:0]  size,
                                             input logic [1:0]  burst);
      unique case (burst)
         BURST_FIXED:            return addr;
         BURST_INCR, BURST_WRAP: return addr + (32'd1 << size);
         default:                return addr + (32'd1 << size);
      endcase
   endfunction

endpackage

// File: rtl/axi_bar_ram.sv
// Scratch storage: one write port with 16 byte enables, one combinational read port.
module axi_bar_ram #(
   parameter int unsigned DEPTH  = 64,
   parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [15:0]       wbe_i,
   input  logic [127:0]      wdata_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [127:0]      rdata_o
);

   for (genvar gi = 0; gi < 16; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];

      always_ff @(posedge clk_i) begin
         if (we_i && wbe_i[gi]) begin
            lane_mem[waddr_i] <= wdata_i[gi*8 +: 8];
         end
      end

      assign rdata_o[gi*8 +: 8] = lane_mem[raddr_i];
   end

endmodule

// File: rtl/axi_bar_responder.sv
// AXI4 BAR responder: ID word, write-beat counter and byte-addressable scratch RAM.
// Optional macro AXI_BAR_DECERR_EN reports out-of-range beats as DECERR.
module axi_bar_responder
   import axi_bar_pkg::*;
#(
   parameter int unsigned  DEPTH    = 64,
   parameter logic [127:0] ID_VALUE = 128'h0000_0000_0000_0000_0000_0000_ACE0_0001
) (
   input  logic         axi_clk_pcie,
   input  logic         sys_resetn,
   input  logic [31:0]  s_axi_pcie_awaddr_i,
   input  logic [7:0]   s_axi_pcie_awlen_i,
   input  logic [2:0]   s_axi_pcie_awsize_i,
   input  logic [1:0]   s_axi_pcie_awburst_i,
   input  logic [2:0]   s_axi_pcie_awprot_i,
   input  logic         s_axi_pcie_awlock_i,
   input  logic [3:0]   s_axi_pcie_awcache_i,
   input  logic         s_axi_pcie_awvalid_i,
   output logic         s_axi_pcie_awready_o,
   input  logic [127:0] s_axi_pcie_wdata_i,
   input  logic [15:0]  s_axi_pcie_wstrb_i,
   input  logic         s_axi_pcie_wlast_i,
   input  logic         s_axi_pcie_wvalid_i,
   output logic         s_axi_pcie_wready_o,
   output logic [1:0]   s_axi_pcie_bresp_o,
   output logic         s_axi_pcie_bvalid_o,
   input  logic         s_axi_pcie_bready_i,
   input  logic [31:0]  s_axi_pcie_araddr_i,
   input  logic [7:0]   s_axi_pcie_arlen_i,
   input  logic [2:0]   s_axi_pcie_arsize_i,
   input  logic [1:0]   s_axi_pcie_arburst_i,
   input  logic [2:0]   s_axi_pcie_arprot_i,
   input  logic         s_axi_pcie_arlock_i,
   input  logic [3:0]   s_axi_pcie_arcache_i,
   input  logic         s_axi_pcie_arvalid_i,
   output logic         s_axi_pcie_arready_o,
   output logic [127:0] s_axi_pcie_rdata_o,
   output logic [1:0]   s_axi_pcie_rresp_o,
   output logic         s_axi_pcie_rlast_o,
   output logic         s_axi_pcie_rvalid_o,
   input  logic         s_axi_pcie_rready_i
);

   localparam int unsigned       ADDR_W     = $clog2(DEPTH);
   localparam logic [31:0]       ADDR_LIMIT = 32'(DEPTH * 16);
   localparam logic [ADDR_W-1:0] IDX_ID     = ADDR_W'(WORD_ID);
   localparam logic [ADDR_W-1:0] IDX_WRCNT  = ADDR_W'(WORD_WRCNT);
`ifdef AXI_BAR_DECERR_EN
   localparam logic [1:0]        RESP_OOR   = RESP_DECERR;
`else
   localparam logic [1:0]        RESP_OOR   = RESP_OKAY;
`endif

   w_state_t     w_state_q, w_state_d;
   logic [31:0]  waddr_q, waddr_d;
   logic [7:0]   wrem_q, wrem_d;
   logic [2:0]   wsize_q, wsize_d;
   logic [1:0]   wburst_q, wburst_d;
   logic         wslverr_q, wslverr_d, wdecerr_q, wdecerr_d;
   logic [1:0]   bresp_q, bresp_d;
   logic [31:0]  wrcnt_q, wrcnt_d;
   logic         awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;

   r_state_t     r_state_q, r_state_d;
   logic [31:0]  raddr_q, raddr_d;
   logic [7:0]   rrem_q, rrem_d;
   logic [2:0]   rsize_q, rsize_d;
   logic [1:0]   rburst_q, rburst_d;
   logic [127:0] rdata_q, rdata_d;
   logic [1:0]   rresp_q, rresp_d;
   logic         rlast_q, rlast_d, arready_q, arready_d, rvalid_q, rvalid_d;

   logic              ram_we;
   logic [127:0]      ram_rdata, rd_data_sel;
   logic [1:0]        rd_resp_sel;
   logic [31:0]       rd_addr;
   logic [ADDR_W-1:0] w_word, rd_word;
   logic              w_in_range, rd_in_range;
   logic              unused_ok;

   wire aw_hs = s_axi_pcie_awvalid_i & awready_q;
   wire w_hs  = s_axi_pcie_wvalid_i & wready_q;
   wire b_hs  = bvalid_q & s_axi_pcie_bready_i;
   wire ar_hs = s_axi_pcie_arvalid_i & arready_q;
   wire r_hs  = rvalid_q & s_axi_pcie_rready_i;

   assign w_word      = waddr_q[ADDR_W+3:4];
   assign w_in_range  = waddr_q < ADDR_LIMIT;
   // In idle the incoming AR address is decoded so the first beat registers on the handshake edge.
   assign rd_addr     = (r_state_q == R_IDLE) ? s_axi_pcie_araddr_i : raddr_q;
   assign rd_word     = rd_addr[ADDR_W+3:4];
   assign rd_in_range = rd_addr < ADDR_LIMIT;

   axi_bar_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
      .clk_i   (axi_clk_pcie),
      .we_i    (ram_we),
      .waddr_i (w_word),
      .wbe_i   (s_axi_pcie_wstrb_i),
      .wdata_i (s_axi_pcie_wdata_i),
      .raddr_i (rd_word),
      .rdata_o (ram_rdata)
   );

   always_comb begin
      rd_data_sel = ram_rdata;
      rd_resp_sel = RESP_OKAY;
      if (!rd_in_range) begin
         rd_data_sel = '0;
         rd_resp_sel = RESP_OOR;
      end else if (rd_word == IDX_ID) begin
         rd_data_sel = ID_VALUE;
      end else if (rd_word == IDX_WRCNT) begin
         rd_data_sel = {96'b0, wrcnt_q};
      end
   end

   always_ff @(posedge axi_clk_pcie or negedge sys_resetn) begin
      if (!sys_resetn) begin
         w_state_q <= W_IDLE;   waddr_q   <= '0;  wrem_q    <= '0;
         wsize_q   <= '0;       wburst_q  <= '0;  wslverr_q <= 1'b0;
         wdecerr_q <= 1'b0;     bresp_q   <= '0;  wrcnt_q   <= '0;
         awready_q <= 1'b0;     wready_q  <= 1'b0; bvalid_q <= 1'b0;
      end else begin
         w_state_q <= w_state_d; waddr_q  <= waddr_d;  wrem_q    <= wrem_d;
         wsize_q   <= wsize_d;   wburst_q <= wburst_d; wslverr_q <= wslverr_d;
         wdecerr_q <= wdecerr_d; bresp_q  <= bresp_d;  wrcnt_q   <= wrcnt_d;
         awready_q <= awready_d; wready_q <= wready_d; bvalid_q  <= bvalid_d;
      end
   end

   always_comb begin
      w_state_d = w_state_q; waddr_d   = waddr_q;   wrem_d  = wrem_q;
      wsize_d   = wsize_q;   wburst_d  = wburst_q;  wslverr_d = wslverr_q;
      wdecerr_d = wdecerr_q; bresp_d   = bresp_q;   wrcnt_d = wrcnt_q;
      ram_we    = 1'b0;
      unique case (w_state_q)
         W_IDLE: if (aw_hs) begin
            w_state_d = W_DATA;               waddr_d   = s_axi_pcie_awaddr_i;
            wrem_d    = s_axi_pcie_awlen_i;   wsize_d   = s_axi_pcie_awsize_i;
            wburst_d  = s_axi_pcie_awburst_i; wslverr_d = 1'b0;
            wdecerr_d = 1'b0;
         end
         W_DATA: if (w_hs) begin
            waddr_d = next_addr(waddr_q, wsize_q, wburst_q);
            wrem_d  = wrem_q - 8'd1;
            if (s_axi_pcie_wlast_i != (wrem_q == 8'd0)) wslverr_d = 1'b1;
            if (w_in_range) begin
               wrcnt_d = wrcnt_q + 32'd1;
               ram_we  = (w_word > IDX_WRCNT);
            end else begin
               wdecerr_d = 1'b1;
            end
            if (wrem_q == 8'd0) begin
               w_state_d = W_RESP;
               bresp_d   = wslverr_d ? RESP_SLVERR : (wdecerr_d ? RESP_OOR : RESP_OKAY);
            end
         end
         W_RESP: if (b_hs) w_state_d = W_IDLE;
         default: w_state_d = W_IDLE;
      endcase
   end

   // Handshake outputs are registered from the next state, so they stay low through reset.
   always_comb begin
      awready_d = (w_state_d == W_IDLE);
      wready_d  = (w_state_d == W_DATA);
      bvalid_d  = (w_state_d == W_RESP);
      arready_d = (r_state_d == R_IDLE);
      rvalid_d  = (r_state_d == R_DATA);
   end

   always_ff @(posedge axi_clk_pcie or negedge sys_resetn) begin
      if (!sys_resetn) begin
         r_state_q <= R_IDLE; raddr_q  <= '0;   rrem_q    <= '0;
         rsize_q   <= '0;     rburst_q <= '0;   rdata_q   <= '0;
         rresp_q   <= '0;     rlast_q  <= 1'b0; arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
      end else begin
         r_state_q <= r_state_d; raddr_q  <= raddr_d;  rrem_q    <= rrem_d;
         rsize_q   <= rsize_d;   rburst_q <= rburst_d; rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;   rlast_q  <= rlast_d;  arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
      end
   end

   always_comb begin
      r_state_d = r_state_q; raddr_d = raddr_q; rrem_d  = rrem_q;
      rsize_d   = rsize_q;   rburst_d = rburst_q; rdata_d = rdata_q;
      rresp_d   = rresp_q;   rlast_d = rlast_q;
      unique case (r_state_q)
         R_IDLE: if (ar_hs) begin
            r_state_d = R_DATA;
            raddr_d   = next_addr(s_axi_pcie_araddr_i, s_axi_pcie_arsize_i, s_axi_pcie_arburst_i);
            rrem_d    = s_axi_pcie_arlen_i;
            rsize_d   = s_axi_pcie_arsize_i;
            rburst_d  = s_axi_pcie_arburst_i;
            rdata_d   = rd_data_sel;
            rresp_d   = rd_resp_sel;
            rlast_d   = (s_axi_pcie_arlen_i == 8'd0);
         end
         R_DATA: if (r_hs) begin
            if (rlast_q) begin
               r_state_d = R_IDLE;
            end else begin
               rdata_d = rd_data_sel;
               rresp_d = rd_resp_sel;
               rlast_d = (rrem_q == 8'd1);
               rrem_d  = rrem_q - 8'd1;
               raddr_d = next_addr(raddr_q, rsize_q, rburst_q);
            end
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   assign s_axi_pcie_awready_o = awready_q;
   assign s_axi_pcie_wready_o  = wready_q;
   assign s_axi_pcie_bvalid_o  = bvalid_q;
   assign s_axi_pcie_bresp_o   = bresp_q;
   assign s_axi_pcie_arready_o = arready_q;
   assign s_axi_pcie_rvalid_o  = rvalid_q;
   assign s_axi_pcie_rdata_o   = rdata_q;
   assign s_axi_pcie_rresp_o   = rresp_q;
   assign s_axi_pcie_rlast_o   = rlast_q;

   assign unused_ok = ^{s_axi_pcie_awprot_i, s_axi_pcie_awlock_i, s_axi_pcie_awcache_i,
                        s_axi_pcie_arprot_i, s_axi_pcie_arlock_i, s_axi_pcie_arcache_i};

endmodule
